chimp_seq_ctrl: RTL and testbench
=================================

# chimp_seq_ctrl

Parametrised control path for the chimp memory test, replacing the one-state-per-number controller. Level, target number, strikes and best score are counters, so a single CHOOSE state serves any level up to MAX_LEVEL. Adds configurable lives, win detection, a best-level register and optional number hiding after the first pick. The block sits between the keyboard/board-compare datapath and the board loader/VGA renderer.

## Interface
- MAX_LEVEL, 31: highest level; completing it wins the game.
- START_LEVEL, 4: level at game start; 1 ≤ START_LEVEL ≤ MAX_LEVEL.
- LIVES, 3: wrong picks allowed per game (≥1); strikes do not reset on level-up.
- HIDE_AFTER_FIRST, 1: 1 = oShowEnable drops once number 1 is picked; 0 = numbers shown throughout CHOOSE.
- LW = $clog2(MAX_LEVEL+1), SW = $clog2(LIVES+1): derived, not overridable.

Ports:
- clk  in  1  system clock.
- iResetn  in  1  synchronous, active-low reset.
- iSpace  in  1  start/continue key, level-sensitive.
- iDoneLoad  in  1  loader finished placing numbers, pulse or level.
- iChoseCorrectNum  in  1  1-cycle pulse, correct cell picked.
- iChoseWrongNum  in  1  1-cycle pulse, wrong cell picked.
- oNumToChoose  out  LW  expected number; 0 outside CHOOSE.
- oLevel  out  LW  current level.
- oStrikes  out  SW  wrong picks this game.
- oBest  out  LW  highest level completed since reset.
- oLoadEnable  out  1  loader may place numbers.
- oShowEnable  out  1  renderer draws numbers.
- oResetBoard  out  1  clear board.
- oGameOver  out  1  game ended on lives exhausted.
- oWin  out  1  game ended on MAX_LEVEL completed.

## Operation
- States: IDLE, ARM, CLEAR, LOAD, CHOOSE, ADVANCE, FAIL, OVER.
- IDLE: level=START_LEVEL, strikes=0, num=0, oResetBoard=1. iSpace=1 -> ARM.
- ARM: oResetBoard=1. Waits for iSpace=0 (release), then -> CLEAR.
- CLEAR: one cycle with oResetBoard=1, num=0, then -> LOAD.
- LOAD: oLoadEnable=1, oShowEnable=1. iDoneLoad=1 -> CHOOSE, num=1.
- CHOOSE: oNumToChoose=num. oShowEnable=1 if HIDE_AFTER_FIRST=0 or num==1, else 0.
  - iChoseWrongNum has priority over iChoseCorrectNum when both are asserted -> FAIL.
  - Correct with num<level: num+1, stay in CHOOSE.
  - Correct with num==level -> ADVANCE.
  - No pulse: hold.
- ADVANCE: one cycle, oResetBoard=1. best=max(best,level).
  - level==MAX_LEVEL -> OVER with win flag set.
  - Otherwise level+1 -> CLEAR.
- FAIL: one cycle, oResetBoard=1, strikes+1.
  - New strikes==LIVES -> OVER with win flag clear.
  - Otherwise -> CLEAR, replaying the same level.
- OVER: oGameOver=!win, oWin=win, level/strikes/best held for display. iSpace=1 -> ARM with level=START_LEVEL, strikes=0, win=0. best is retained.
- Pick pulses outside CHOOSE are ignored. iSpace is ignored outside IDLE, ARM and OVER.
- Counters never wrap. level saturates at MAX_LEVEL (OVER is taken first). strikes saturate at LIVES.

## Timing
- Moore outputs decoded from registered state and counters; no combinational input-to-output paths.
- Reset values: state=IDLE, level=START_LEVEL, strikes=0, best=0, num=0, win=0. Outputs at reset: oResetBoard=1; all other 1-bit outputs 0; oNumToChoose=0; oLevel=START_LEVEL.
- Pick pulse in cycle t -> oNumToChoose/state updated in t+1.
- Final correct pick at t: ADVANCE at t+1, CLEAR at t+2, LOAD at t+3.
- Wrong pick at t: FAIL at t+1, CLEAR or OVER at t+2.
- iResetn=0 in any state, including mid-CHOOSE or mid-LOAD, forces all reset values at the next edge. best is cleared.
- iDoneLoad held high: accepted once in LOAD; ignored elsewhere.

## Structure
- Package chimp_pkg: state enum (chimp_state_t), state encoding, and the function that computes LW from MAX_LEVEL. Shared with the board loader and renderer.
- Sub-module chimp_score_keeper holds the level, strikes, best and win registers, with inc/clear/replay controls driven by the FSM. The FSM and output decode live in chimp_seq_ctrl.

## Test plan
- Reset, iSpace pulse, iDoneLoad, 4 correct picks (START_LEVEL=4) -> oNumToChoose steps 1,2,3,4; oLevel=5; oBest=4; board reset seen in ADVANCE and CLEAR.
- HIDE_AFTER_FIRST=1: in CHOOSE, oShowEnable=1 while num=1; after the first correct pick, oShowEnable=0.
- LIVES=3: three wrong picks -> oStrikes 1,2,3; level held at 4; oGameOver=1 after the third; iSpace then returns to level 4 with strikes 0 and oBest retained.
- Same-cycle correct and wrong pulses -> FAIL taken; num unchanged.
- MAX_LEVEL=5, START_LEVEL=4: complete levels 4 and 5 -> oWin=1, oGameOver=0, oBest=5, oLevel=5.
- iResetn=0 while num=3 in CHOOSE -> next cycle: IDLE, oNumToChoose=0, oBest=0, oResetBoard=1.

Source files
------------

// File: rtl/chimp_pkg.sv
// chimp_pkg: shared state encoding and level-width helper for the chimp memory game
package chimp_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CLEAR   = 3'd2,
    S_LOAD    = 3'd3,
    S_CHOOSE  = 3'd4,
    S_ADVANCE = 3'd5,
    S_FAIL    = 3'd6,
    S_OVER    = 3'd7
  } chimp_state_t;
  function automatic int lw_of(input int max_level);
    return $clog2(max_level + 1);
  endfunction
endpackage

// File: rtl/chimp_score_keeper.sv
// chimp_score_keeper: level, strikes, best-level and win registers driven by new_game/advance/strike controls
module chimp_score_keeper #(
  parameter int MAX_LEVEL   = 31,
  parameter int START_LEVEL = 4,
  parameter int LIVES       = 3,
  parameter int LW          = 5,
  parameter int SW          = 2
) (
  input  logic          clk,
  input  logic          iResetn,
  input  logic          new_game_i,
  input  logic          advance_i,
  input  logic          strike_i,
  output logic [LW-1:0] level_o,
  output logic [LW-1:0] best_o,
  output logic [SW-1:0] strikes_o,
  output logic          win_o
);
  localparam logic [LW-1:0] LVL_START = LW'(START_LEVEL);
  localparam logic [LW-1:0] LVL_MAX   = LW'(MAX_LEVEL);
  localparam logic [SW-1:0] STK_MAX   = SW'(LIVES);
  logic [LW-1:0] level_q, level_d, best_q, best_d;
  logic [SW-1:0] strikes_q, strikes_d;
  logic          win_q, win_d;
  always_comb begin
    level_d   = new_game_i ? LVL_START : (advance_i && level_q != LVL_MAX) ? level_q + LW'(1) : level_q;
    strikes_d = new_game_i ? '0 : (strike_i && strikes_q != STK_MAX) ? strikes_q + SW'(1) : strikes_q;
    win_d     = new_game_i ? 1'b0 : (advance_i && level_q == LVL_MAX) ? 1'b1 : win_q;
    best_d    = (advance_i && level_q > best_q) ? level_q : best_q;
  end
  always_ff @(posedge clk) begin
    if (!iResetn) begin
      level_q   <= LVL_START;
      strikes_q <= '0;
      best_q    <= '0;
      win_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      strikes_q <= strikes_d;
      best_q    <= best_d;
      win_q     <= win_d;
    end
  end
  assign level_o   = level_q;
  assign best_o    = best_q;
  assign strikes_o = strikes_q;
  assign win_o     = win_q;
endmodule

// File: rtl/chimp_seq_ctrl.sv
// chimp_seq_ctrl: counter-based game sequencer between pick/loader datapath and board loader/renderer
module chimp_seq_ctrl
  import chimp_pkg::*;
#(
  parameter int MAX_LEVEL        = 31,
  parameter int START_LEVEL      = 4,
  parameter int LIVES            = 3,
  parameter int HIDE_AFTER_FIRST = 1,
  localparam int LW = lw_of(MAX_LEVEL),
  localparam int SW = $clog2(LIVES + 1)
) (
  input  logic          clk,
  input  logic          iResetn,
  input  logic          iSpace,
  input  logic          iDoneLoad,
  input  logic          iChoseCorrectNum,
  input  logic          iChoseWrongNum,
  output logic [LW-1:0] oNumToChoose,
  output logic [LW-1:0] oLevel,
  output logic [SW-1:0] oStrikes,
  output logic [LW-1:0] oBest,
  output logic          oLoadEnable,
  output logic          oShowEnable,
  output logic          oResetBoard,
  output logic          oGameOver,
  output logic          oWin
);
  localparam logic [LW-1:0] LVL_MAX = LW'(MAX_LEVEL);
  chimp_state_t  state_q, state_d;
  logic [LW-1:0] num_q, num_d, level;
  logic [SW-1:0] strikes;
  logic          win, new_game;
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    new_game = 1'b0;
    case (state_q)
      S_IDLE: begin
        new_game = 1'b1;
        num_d    = '0;
        state_d  = iSpace ? S_ARM : S_IDLE;
      end
      S_ARM:   state_d = iSpace ? S_ARM : S_CLEAR;
      S_CLEAR: begin
        num_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        num_d   = iDoneLoad ? LW'(1) : num_q;
        state_d = iDoneLoad ? S_CHOOSE : S_LOAD;
      end
      S_CHOOSE: begin
        state_d = iChoseWrongNum ? S_FAIL : (iChoseCorrectNum && num_q == level) ? S_ADVANCE : S_CHOOSE;
        num_d   = (!iChoseWrongNum && iChoseCorrectNum && num_q != level) ? num_q + LW'(1) : num_q;
      end
      S_ADVANCE: state_d = level == LVL_MAX ? S_OVER : S_CLEAR;
      S_FAIL:    state_d = strikes == SW'(LIVES - 1) ? S_OVER : S_CLEAR;
      S_OVER: begin
        new_game = iSpace;
        state_d  = iSpace ? S_ARM : S_OVER;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!iResetn) begin
      state_q <= S_IDLE;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
    end
  end
  chimp_score_keeper #(
    .MAX_LEVEL  (MAX_LEVEL),
    .START_LEVEL(START_LEVEL),
    .LIVES      (LIVES),
    .LW         (LW),
    .SW         (SW)
  ) u_score (
    .clk       (clk),
    .iResetn   (iResetn),
    .new_game_i(new_game),
    .advance_i (state_q == S_ADVANCE),
    .strike_i  (state_q == S_FAIL),
    .level_o   (level),
    .best_o    (oBest),
    .strikes_o (strikes),
    .win_o     (win)
  );
  assign oNumToChoose = state_q == S_CHOOSE ? num_q : '0;
  assign oLevel       = level;
  assign oStrikes     = strikes;
  assign oLoadEnable  = state_q == S_LOAD;
  assign oShowEnable  = state_q == S_LOAD || (state_q == S_CHOOSE && (HIDE_AFTER_FIRST == 0 || num_q == LW'(1)));
  assign oResetBoard  = state_q inside {S_IDLE, S_ARM, S_CLEAR, S_ADVANCE, S_FAIL};
  assign oGameOver    = state_q == S_OVER && !win;
  assign oWin         = state_q == S_OVER && win;
endmodule

// File: tb/tb_chimp_seq_ctrl.sv
// tb_chimp_seq_ctrl: table-driven check of the chimp sequencer with MAX_LEVEL=5, START_LEVEL=4, LIVES=3
module tb_chimp_seq_ctrl;
  logic clk = 1'b0, iResetn = 1'b0, iSpace = 1'b0, iDoneLoad = 1'b0;
  logic iChoseCorrectNum = 1'b0, iChoseWrongNum = 1'b0;
  logic [2:0] oNumToChoose, oLevel, oBest;
  logic [1:0] oStrikes;
  logic oLoadEnable, oShowEnable, oResetBoard, oGameOver, oWin;
  logic [15:0] outs;
  int total = 0, bad = 0;
  typedef struct {
    logic [4:0]  in;
    logic [15:0] exp;
  } vec_t;
  vec_t vq[$];
  localparam logic [4:0] RST = 5'b00000, NONE = 5'b10000, SP = 5'b11000, DN = 5'b10100;
  localparam logic [4:0] CO = 5'b10010, WR = 5'b10001;
  localparam logic [4:0] F_NONE = 5'b00000, F_LOAD = 5'b11000, F_SH = 5'b01000;
  localparam logic [4:0] F_RB = 5'b00100, F_GO = 5'b00010, F_WIN = 5'b00001;
  always #5 clk = ~clk;
  chimp_seq_ctrl #(
    .MAX_LEVEL(5), .START_LEVEL(4), .LIVES(3), .HIDE_AFTER_FIRST(1)
  ) dut (
    .clk(clk), .iResetn(iResetn), .iSpace(iSpace), .iDoneLoad(iDoneLoad),
    .iChoseCorrectNum(iChoseCorrectNum), .iChoseWrongNum(iChoseWrongNum),
    .oNumToChoose(oNumToChoose), .oLevel(oLevel), .oStrikes(oStrikes), .oBest(oBest),
    .oLoadEnable(oLoadEnable), .oShowEnable(oShowEnable), .oResetBoard(oResetBoard),
    .oGameOver(oGameOver), .oWin(oWin)
  );
  assign outs = {oNumToChoose, oLevel, oStrikes, oBest, oLoadEnable, oShowEnable, oResetBoard, oGameOver, oWin};
  task automatic add(input logic [4:0] in, input int num, lvl, stk, best, input logic [4:0] fl);
    vec_t v;
    v.in  = in;
    v.exp = {3'(num), 3'(lvl), 2'(stk), 3'(best), fl};
    vq.push_back(v);
  endtask
  task automatic drive(input logic [4:0] in);
    {iResetn, iSpace, iDoneLoad, iChoseCorrectNum, iChoseWrongNum} = in;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  initial begin
    add(RST, 0, 4, 0, 0, F_RB);
    add(SP, 0, 4, 0, 0, F_RB);
    add(SP, 0, 4, 0, 0, F_RB);
    add(NONE, 0, 4, 0, 0, F_RB);
    add(NONE, 0, 4, 0, 0, F_LOAD);
    add(DN, 1, 4, 0, 0, F_SH);
    add(DN | CO, 2, 4, 0, 0, F_NONE);
    add(CO, 3, 4, 0, 0, F_NONE);
    add(NONE, 3, 4, 0, 0, F_NONE);
    add(CO, 4, 4, 0, 0, F_NONE);
    add(CO, 0, 4, 0, 0, F_RB);
    add(NONE, 0, 5, 0, 4, F_RB);
    add(CO, 0, 5, 0, 4, F_LOAD);
    add(SP, 0, 5, 0, 4, F_LOAD);
    add(DN, 1, 5, 0, 4, F_SH);
    add(CO | WR, 0, 5, 0, 4, F_RB);
    add(NONE, 0, 5, 1, 4, F_RB);
    add(NONE, 0, 5, 1, 4, F_LOAD);
    add(DN, 1, 5, 1, 4, F_SH);
    for (int k = 2; k <= 5; k++) add(CO, k, 5, 1, 4, F_NONE);
    add(CO, 0, 5, 1, 4, F_RB);
    add(NONE, 0, 5, 1, 5, F_WIN);
    add(NONE, 0, 5, 1, 5, F_WIN);
    add(SP, 0, 4, 0, 5, F_RB);
    add(NONE, 0, 4, 0, 5, F_RB);
    add(NONE, 0, 4, 0, 5, F_LOAD);
    for (int s = 0; s < 3; s++) begin
      add(DN, 1, 4, s, 5, F_SH);
      add(WR, 0, 4, s, 5, F_RB);
      if (s < 2) begin
        add(NONE, 0, 4, s + 1, 5, F_RB);
        add(NONE, 0, 4, s + 1, 5, F_LOAD);
      end else begin
        add(NONE, 0, 4, 3, 5, F_GO);
      end
    end
    add(CO, 0, 4, 3, 5, F_GO);
    add(SP, 0, 4, 0, 5, F_RB);
    add(NONE, 0, 4, 0, 5, F_RB);
    add(NONE, 0, 4, 0, 5, F_LOAD);
    add(DN, 1, 4, 0, 5, F_SH);
    add(CO, 2, 4, 0, 5, F_NONE);
    add(CO, 3, 4, 0, 5, F_NONE);
    add(5'b00010, 0, 4, 0, 0, F_RB);
    add(SP, 0, 4, 0, 0, F_RB);
    add(NONE, 0, 4, 0, 0, F_RB);
    add(NONE, 0, 4, 0, 0, F_LOAD);
    add(5'b00100, 0, 4, 0, 0, F_RB);
    add(NONE, 0, 4, 0, 0, F_RB);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].in);
      check($sformatf("vec%0d", i), outs, vq[i].exp);
    end
    drive(SP);
    drive(NONE);
    begin
      int n;
      n = 0;
      {iResetn, iSpace, iDoneLoad, iChoseCorrectNum, iChoseWrongNum} = 5'b10110;
      while (!oWin && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("win_reached", 16'({oWin, oGameOver}), 16'b10);
      check("win_best_level", 16'({oBest, oLevel}), 16'({3'd5, 3'd5}));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
